// File: rtl/opn_bus_pkg.sv
// Shared types, default timing and named chip registers for the OPN bus write sequencer.
package opn_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADR_WR,
    ADR_HOLD,
    DAT_WR,
    DAT_HOLD,
    RECOVER
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  localparam int DEF_DEPTH    = 8;
  localparam int DEF_WR_PULSE = 1;
  localparam int DEF_GAP      = 1;
  localparam int DEF_RECOVERY = 479;

  localparam logic [7:0] REG_KON     = 8'h28;
  localparam logic [7:0] REG_DTMUL   = 8'h30;
  localparam logic [7:0] REG_TL      = 8'h40;
  localparam logic [7:0] REG_KSAR    = 8'h50;
  localparam logic [7:0] REG_DR      = 8'h60;
  localparam logic [7:0] REG_SR      = 8'h70;
  localparam logic [7:0] REG_SLRR    = 8'h80;
  localparam logic [7:0] REG_SSGEG   = 8'h90;
  localparam logic [7:0] REG_FNUM_LO = 8'hA0;
  localparam logic [7:0] REG_FNUM_HI = 8'hA4;
  localparam logic [7:0] REG_FBCN    = 8'hB0;

  // True on the last cen-qualified cycle of a phase lasting len cycles.
  function automatic logic phase_done(input int cnt, input int len);
    return (cnt + 1) >= len;
  endfunction

endpackage

// File: rtl/opn_req_fifo.sv
// Synchronous DEPTH x 16 request FIFO with occupancy count; caller guarantees no
// push when full and no pop when empty.
module opn_req_fifo
  import opn_bus_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   push,
  input  req_t                   push_data,
  input  logic                   pop,
  output req_t                   head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  req_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // NOTE: storage is not reset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: non-blocking assignments keep every register update in this edge order-independent.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/opn_write_sequencer.sv
// Queued register-write engine: buffers {addr,data} requests and replays each as the
// two-phase jt12 CPU-bus write (addr=0 then addr=1) followed by a recovery wait.
module opn_write_sequencer
  import opn_bus_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WR_PULSE = DEF_WR_PULSE,
  parameter int GAP      = DEF_GAP,
  parameter int RECOVERY = DEF_RECOVERY
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   req_valid,
  input  logic [7:0]             req_addr,
  input  logic [7:0]             req_data,
  output logic                   req_ready,
  output logic                   bus_addr,
  output logic [7:0]             bus_din,
  output logic                   bus_cs_n,
  output logic                   bus_wr_n,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int MAX_PG = (WR_PULSE > GAP) ? WR_PULSE : GAP;
  localparam int MAXC   = (RECOVERY > MAX_PG) ? RECOVERY : MAX_PG;
  localparam int CW     = (MAXC < 2) ? 1 : $clog2(MAXC);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    data_q;
  req_t          fifo_head;
  logic          push;
  logic          pop;
  logic          done;

  assign req_ready = (level != LW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = cen && (state == IDLE) && (level != '0);
  assign busy      = (level != '0) || (state != IDLE);

  opn_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in    (clk_in),
    .rst       (rst),
    .push      (push),
    .push_data ('{addr: req_addr, data: req_data}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (level)
  );

  // NOTE: default assignment first so no path through the case leaves done unassigned (no latch).
  always_comb begin
    done = 1'b0;
    case (state)
      ADR_WR, DAT_WR:     done = phase_done(int'(cnt), WR_PULSE);
      ADR_HOLD, DAT_HOLD: done = phase_done(int'(cnt), GAP);
      RECOVER:            done = phase_done(int'(cnt), RECOVERY);
      default:            done = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      bus_cs_n <= 1'b1;
      bus_wr_n <= 1'b1;
      bus_addr <= 1'b0;
      bus_din  <= '0;
    end else if (cen) begin
      // Counter restarts on every phase change so each state measures its own length.
      if (state != IDLE) cnt <= done ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (level != '0) begin
          bus_cs_n <= 1'b0;
          bus_addr <= 1'b0;
          bus_din  <= fifo_head.addr;
          data_q   <= fifo_head.data;
          bus_wr_n <= 1'b0;
          state    <= ADR_WR;
        end
        ADR_WR: if (done) begin
          bus_wr_n <= 1'b1;
          state    <= ADR_HOLD;
        end
        ADR_HOLD: if (done) begin
          bus_addr <= 1'b1;
          bus_din  <= data_q;
          bus_wr_n <= 1'b0;
          state    <= DAT_WR;
        end
        DAT_WR: if (done) begin
          bus_wr_n <= 1'b1;
          state    <= DAT_HOLD;
        end
        DAT_HOLD: if (done) begin
          bus_addr <= 1'b0;
          bus_cs_n <= 1'b1;
          state    <= (RECOVERY == 0) ? IDLE : RECOVER;
        end
        RECOVER: if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
